// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad sequencing controller for the calculator.
// Decodes the level-held 4-bit keypad command into edge events, builds two
// decimal operands digit by digit, launches the ALU with a start/done
// handshake, and guards the wait for the ALU with a timeout.
module calc_ctrl #(
  parameter int DIGITS  = 8,
  parameter int W       = 27,
  parameter int TIMEOUT = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   cmd,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  output logic         alu_start,
  input  logic         alu_done,
  input  logic [W-1:0] alu_result,
  input  logic         alu_ovf,
  output logic [W-1:0] disp_value,
  output logic [1:0]   status,
  output logic [2:0]   EA,
  output logic [2:0]   PE
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_WAIT_A = 3'd0;
  localparam logic [2:0] S_WAIT_B = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_BUSY   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam logic [3:0] CMD_ADD  = 4'b1010;
  localparam logic [3:0] CMD_SUB  = 4'b1011;
  localparam logic [3:0] CMD_MUL  = 4'b1100;
  localparam logic [3:0] CMD_BKSP = 4'b1101;
  localparam logic [3:0] CMD_EQ   = 4'b1110;
  localparam logic [3:0] CMD_IDLE = 4'b1111;

  localparam logic [1:0] ST_READY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_ERROR = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    cmd_q;

  logic evt, is_digit, is_op, is_bksp, is_eq;
  logic can_add, can_del;
  logic [1:0] op_code;

  // A*10 + d is formed four bits wider than the operand; the digit count
  // bound keeps the true value inside W bits, so truncation loses nothing.
  function automatic logic [W-1:0] append_digit(input logic [W-1:0] v,
                                                input logic [3:0]   d);
    logic [W+3:0] wide;
    wide = ({4'b0000, v} * (W+4)'(10)) + (W+4)'(d);
    return wide[W-1:0];
  endfunction

  // Keypad operator code to ALU operator encoding.
  always_comb begin
    unique case (cmd)
      CMD_SUB: op_code = 2'b01;
      CMD_MUL: op_code = 2'b10;
      default: op_code = 2'b00;
    endcase
  end

  // Event decode: a new, non-idle key compared with last cycle's command.
  always_comb begin
    evt      = (cmd != cmd_q) && (cmd != CMD_IDLE);
    is_digit = evt && (cmd <= 4'd9);
    is_op    = evt && (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_MUL);
    is_bksp  = evt && (cmd == CMD_BKSP);
    is_eq    = evt && (cmd == CMD_EQ);
    can_add  = cnt_q < CW'(DIGITS);
    can_del  = cnt_q != '0;
  end

  // Next-state and datapath update for every control register.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tmr_d   = tmr_q;

    unique case (state_q)
      S_WAIT_A: begin
        if (is_digit && can_add) begin
          a_d   = append_digit(a_q, cmd);
          cnt_d = cnt_q + CW'(1);
        end else if (is_bksp && can_del) begin
          a_d   = a_q / W'(10);
          cnt_d = cnt_q - CW'(1);
        end else if (is_op) begin
          op_d    = op_code;
          b_d     = '0;
          cnt_d   = '0;
          state_d = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (is_digit && can_add) begin
          b_d   = append_digit(b_q, cmd);
          cnt_d = cnt_q + CW'(1);
        end else if (is_bksp && can_del) begin
          b_d   = b_q / W'(10);
          cnt_d = cnt_q - CW'(1);
        end else if (is_op) begin
          op_d = op_code;
        end else if (is_eq) begin
          state_d = S_START;
        end
      end
      S_START: begin
        tmr_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        // A done pulse takes priority over a timeout in the same cycle.
        if (alu_done) begin
          if (alu_ovf) begin
            state_d = S_ERROR;
          end else begin
            a_d     = alu_result;
            state_d = S_RESULT;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
          if ({1'b0, tmr_q} + (TW+1)'(1) == (TW+1)'(TIMEOUT)) begin
            state_d = S_ERROR;
          end
        end
      end
      S_RESULT: begin
        if (is_digit) begin
          a_d     = W'(cmd);
          cnt_d   = CW'(1);
          state_d = S_WAIT_A;
        end else if (is_op) begin
          op_d    = op_code;
          b_d     = '0;
          cnt_d   = '0;
          state_d = S_WAIT_B;
        end else if (is_eq) begin
          state_d = S_START;
        end
      end
      S_ERROR: begin
        if (is_digit) begin
          a_d     = W'(cmd);
          b_d     = '0;
          cnt_d   = CW'(1);
          state_d = S_WAIT_A;
        end
      end
      default: state_d = S_WAIT_A;
    endcase
  end

  // State and operand registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      tmr_q   <= '0;
      cmd_q   <= CMD_IDLE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tmr_q   <= tmr_d;
      cmd_q   <= cmd;
    end
  end

  // Display source and status LEDs derived from the current state.
  always_comb begin
    disp_value = '0;
    status     = ST_READY;
    unique case (state_q)
      S_WAIT_A, S_RESULT:       disp_value = a_q;
      S_WAIT_B, S_START, S_BUSY: disp_value = b_q;
      default:                  disp_value = '0;
    endcase
    if (state_q == S_ERROR) begin
      status = ST_ERROR;
    end else if (state_q == S_START || state_q == S_BUSY) begin
      status = ST_BUSY;
    end else if ((state_q == S_WAIT_A || state_q == S_WAIT_B) &&
                 cnt_q == CW'(DIGITS)) begin
      status = ST_FULL;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_start = (state_q == S_START);
  assign EA        = state_q;
  assign PE        = state_d;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed bench for calc_ctrl with a behavioural ALU that
// answers a configurable number of BUSY cycles after each start pulse.
module tb_calc_ctrl;

  localparam int W = 27;

  logic         clock;
  logic         reset;
  logic [3:0]   cmd;
  logic [W-1:0] alu_a, alu_b, alu_result, disp_value;
  logic [1:0]   alu_op, status;
  logic         alu_start, alu_done, alu_ovf;
  logic [2:0]   EA, PE;

  int checks    = 0;
  int failures  = 0;
  int start_cnt = 0;
  int alu_delay = 5;   // BUSY cycle on which done fires; 0 = never

  calc_ctrl #(.DIGITS(8), .W(W), .TIMEOUT(255)) dut (
    .clock(clock), .reset(reset), .cmd(cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .disp_value(disp_value), .status(status), .EA(EA), .PE(PE)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (alu_start) start_cnt++;
  endtask

  task automatic key(input logic [3:0] k);
    cmd = k;
    tick();
    cmd = 4'hF;
    tick();
  endtask

  task automatic do_reset();
    cmd   = 4'hF;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget,
                            input string tag);
    int n = 0;
    while (EA !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, EA, target);
  endtask

  // Behavioural ALU: captures operands at start, answers after alu_delay.
  initial begin
    logic          pending;
    int            wait_c;
    logic [W-1:0]  oa, ob;
    logic [1:0]    oo;
    logic [63:0]   r;
    pending    = 1'b0;
    wait_c     = 0;
    alu_done   = 1'b0;
    alu_ovf    = 1'b0;
    alu_result = '0;
    forever begin
      @(posedge clock);
      #1;
      alu_done = 1'b0;
      alu_ovf  = 1'b0;
      if (alu_start) begin
        pending = 1'b1;
        wait_c  = 0;
        oa = alu_a; ob = alu_b; oo = alu_op;
      end else if (pending) begin
        wait_c++;
        if (alu_delay != 0 && wait_c == alu_delay) begin
          pending = 1'b0;
          case (oo)
            2'b01:   r = 64'(oa) - 64'(ob);
            2'b10:   r = 64'(oa) * 64'(ob);
            default: r = 64'(oa) + 64'(ob);
          endcase
          alu_ovf    = (oo == 2'b01 && oa < ob) || (r >= (64'd1 << W));
          alu_result = r[W-1:0];
          alu_done   = 1'b1;
        end
      end
    end
  end

  initial begin
    int busy_n;
    cmd   = 4'hF;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_EA", EA, 0);
    check("rst_PE", PE, 0);
    check("rst_start", alu_start, 0);
    check("rst_disp", disp_value, 0);
    check("rst_status", status, 0);

    // Basic multiply 12 * 3
    key(4'd1);   check("mul_d1", disp_value, 1);
    key(4'd2);   check("mul_d12", disp_value, 12);
    key(4'hC);   check("mul_op_disp", disp_value, 0);
                 check("mul_op_EA", EA, 1);
    key(4'd3);   check("mul_b3", disp_value, 3);
    start_cnt = 0;
    cmd = 4'hE;
    tick();
    check("mul_start_EA", EA, 2);
    check("mul_start", alu_start, 1);
    check("mul_start_status", status, 1);
    cmd = 4'hF;
    tick();
    check("mul_busy_EA", EA, 3);
    check("mul_busy_start", alu_start, 0);
    check("mul_busy_status", status, 1);
    wait_state(3'd4, 50, "mul_result_EA");
    check("mul_result", disp_value, 36);
    check("mul_status", status, 0);
    check("mul_start_pulses", start_cnt, 1);

    // Entry limit and backspace
    do_reset();
    for (int i = 0; i < 8; i++) key(4'd1);
    check("lim_a8", disp_value, 11111111);
    check("lim_full", status, 3);
    key(4'd1);
    check("lim_a9", disp_value, 11111111);
    check("lim_full9", status, 3);
    key(4'hD);
    check("lim_bksp", disp_value, 1111111);
    check("lim_ready", status, 0);

    // Subtract to negative
    do_reset();
    key(4'd3); key(4'hB); key(4'd5); key(4'hE);
    wait_state(3'd5, 50, "neg_EA");
    check("neg_status", status, 2);
    check("neg_disp", disp_value, 0);
    key(4'd7);
    check("neg_recover_EA", EA, 0);
    check("neg_recover_A", disp_value, 7);

    // Chaining and repeat-equals
    do_reset();
    key(4'd2); key(4'hA); key(4'd3); key(4'hE);
    wait_state(3'd4, 50, "chain1_EA");
    check("chain1", disp_value, 5);
    key(4'hE);
    wait_state(3'd4, 50, "chain2_EA");
    check("chain2", disp_value, 8);
    key(4'hC); key(4'd2); key(4'hE);
    wait_state(3'd4, 50, "chain3_EA");
    check("chain3", disp_value, 16);

    // Timeout: ALU never answers
    do_reset();
    alu_delay = 0;
    key(4'd4); key(4'hA); key(4'd1);
    cmd = 4'hE;
    tick();
    check("to_start", EA, 2);
    cmd = 4'hF;
    busy_n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (EA == 3'd3) busy_n++;
      else break;
    end
    check("to_busy_cycles", busy_n, 255);
    check("to_EA", EA, 5);

    // Done on the timeout cycle wins
    alu_delay = 255;
    key(4'd4); key(4'hA); key(4'd1);
    cmd = 4'hE;
    tick();
    cmd = 4'hF;
    busy_n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (EA == 3'd3) busy_n++;
      else break;
    end
    check("to_done_cycles", busy_n, 255);
    check("to_done_EA", EA, 4);
    check("to_done_disp", disp_value, 5);

    // Reset mid-BUSY, late done ignored
    do_reset();
    alu_delay = 20;
    key(4'd2); key(4'hA); key(4'd3); key(4'hE);
    tick(); tick(); tick();
    check("mid_busy_EA", EA, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_EA", EA, 0);
    check("mid_rst_PE", PE, 0);
    check("mid_rst_start", alu_start, 0);
    check("mid_rst_disp", disp_value, 0);
    check("mid_rst_status", status, 0);
    check("mid_rst_a", alu_a, 0);
    check("mid_rst_b", alu_b, 0);
    check("mid_rst_op", alu_op, 0);
    for (int i = 0; i < 25; i++) tick();
    check("late_done_EA", EA, 0);
    check("late_done_disp", disp_value, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
